// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : legv8_ctrl_pkg
// Brief    : Shared states, PS/FS codes, opcodes and decode helper for the
//            LEGv8 control unit.
// Revision : 1.0  initial release
// ============================================================================
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_BRCHK = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_LOAD   = 2'b10;
    localparam logic [1:0] PS_OFFSET = 2'b11;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [4:0] {
        OPC_ADD, OPC_ADDS, OPC_SUB, OPC_SUBS, OPC_AND, OPC_ORR,
        OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORRI,
        OPC_STUR, OPC_LDUR, OPC_B, OPC_CBZ, OPC_CBNZ, OPC_BCOND,
        OPC_INVALID
    } op_t;

    // Widest opcode field first so shorter formats never shadow longer ones.
    function automatic op_t decode_op(input logic [31:0] ir);
        op_t op;
        op = OPC_INVALID;
        case (ir[31:21])
            OP_ADD:  op = OPC_ADD;
            OP_ADDS: op = OPC_ADDS;
            OP_SUB:  op = OPC_SUB;
            OP_SUBS: op = OPC_SUBS;
            OP_AND:  op = OPC_AND;
            OP_ORR:  op = OPC_ORR;
            OP_STUR: op = OPC_STUR;
            OP_LDUR: op = OPC_LDUR;
            default: begin
                case (ir[31:22])
                    OP_ADDI: op = OPC_ADDI;
                    OP_SUBI: op = OPC_SUBI;
                    OP_ANDI: op = OPC_ANDI;
                    OP_ORRI: op = OPC_ORRI;
                    default: begin
                        case (ir[31:24])
                            OP_CBZ:   op = OPC_CBZ;
                            OP_CBNZ:  op = OPC_CBNZ;
                            OP_BCOND: op = OPC_BCOND;
                            default:  op = (ir[31:26] == OP_B) ? OPC_B : OPC_INVALID;
                        endcase
                    end
                endcase
            end
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : legv8_ctrl_if
// Brief    : Control interface between the LEGv8 control unit (master) and
//            the datapath / ROM side (slave).
// Revision : 1.0  initial release
// ============================================================================
interface legv8_ctrl_if #(
    parameter int K_W       = 64,
    parameter int REG_SEL_W = 5
);
    logic [31:0]          inst;
    logic [3:0]           PRESTAT;
    logic [REG_SEL_W-1:0] SA;
    logic [REG_SEL_W-1:0] SB;
    logic [REG_SEL_W-1:0] DA;
    logic                 WR;
    logic [4:0]           FS;
    logic                 C0;
    logic [K_W-1:0]       K;
    logic                 M;
    logic                 EN_ALU;
    logic                 EN_B;
    logic                 EN_PC;
    logic                 EN_ADDR_ALU;
    logic                 EN_ADDR_PC;
    logic                 PC_SEL;
    logic [1:0]           PS;
    logic                 RCS;
    logic                 RWE;
    logic                 ROE;
    logic                 SFL;
    logic                 halted;

    modport master (
        input  inst, PRESTAT,
        output SA, SB, DA, WR, FS, C0, K, M,
        output EN_ALU, EN_B, EN_PC, EN_ADDR_ALU, EN_ADDR_PC,
        output PC_SEL, PS, RCS, RWE, ROE, SFL, halted
    );

    modport slave (
        output inst, PRESTAT,
        input  SA, SB, DA, WR, FS, C0, K, M,
        input  EN_ALU, EN_B, EN_PC, EN_ADDR_ALU, EN_ADDR_PC,
        input  PC_SEL, PS, RCS, RWE, ROE, SFL, halted
    );
endinterface
`default_nettype wire

// File: rtl/legv8_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : legv8_cond_eval
// Brief    : ARM-style condition-code evaluation of cond[3:0] against the
//            registered V/C/N/Z flags.
// Revision : 1.0  initial release
// ============================================================================
module legv8_cond_eval
    import legv8_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_prestat,
    output logic       o_take
);

    logic w_z, w_n, w_c, w_v;
    logic w_base;

    assign w_z = i_prestat[FLAG_Z];
    assign w_n = i_prestat[FLAG_N];
    assign w_c = i_prestat[FLAG_C];
    assign w_v = i_prestat[FLAG_V];

    // cond[0] inverts the base test, except for the always-true pair 111x.
    always_comb begin
        w_base = 1'b1;
        case (i_cond[3:1])
            3'b000:  w_base = w_z;
            3'b001:  w_base = w_c;
            3'b010:  w_base = w_n;
            3'b011:  w_base = w_v;
            3'b100:  w_base = w_c & ~w_z;
            3'b101:  w_base = (w_n == w_v);
            3'b110:  w_base = ~w_z & (w_n == w_v);
            default: w_base = 1'b1;
        endcase
    end

    assign o_take = (i_cond[3:1] == 3'b111) ? 1'b1 : (w_base ^ i_cond[0]);

endmodule
`default_nettype wire

// File: rtl/legv8_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : legv8_control_unit
// Brief    : Multi-cycle LEGv8 sequencer; decodes IR and drives the datapath
//            control word. Define CU_BCOND_EN to decode B.cond.
// Revision : 1.0  initial release
// ============================================================================
module legv8_control_unit
    import legv8_ctrl_pkg::*;
#(
    parameter int K_W       = 64,
    parameter int REG_SEL_W = 5
)(
    input  logic         CLK,
    input  logic         RST,
    legv8_ctrl_if.master cif
);

    state_t      r_state;
    logic [31:0] r_ir;

    op_t w_op_raw;
    op_t w_op;
    logic w_bcond_take;
    logic w_cb_take;

    logic [REG_SEL_W-1:0] w_rd, w_rn, w_rm;
    logic [K_W-1:0]       w_k_imm12, w_k_imm9, w_k_imm19, w_k_imm26;
    logic [4:0]           w_alu_fs;
    logic                 w_alu_sub, w_alu_imm, w_alu_setflags;
    state_t               w_exec_next;

    assign w_op_raw = decode_op(r_ir);

`ifdef CU_BCOND_EN
    assign w_op = w_op_raw;

    legv8_cond_eval u_cond_eval (
        .i_cond    (r_ir[3:0]),
        .i_prestat (cif.PRESTAT),
        .o_take    (w_bcond_take)
    );
`else
    logic w_unused_flags;

    assign w_op           = (w_op_raw == OPC_BCOND) ? OPC_INVALID : w_op_raw;
    assign w_bcond_take   = 1'b0;
    assign w_unused_flags = ^cif.PRESTAT[3:1];
`endif

    assign w_rd = r_ir[4:0];
    assign w_rn = r_ir[9:5];
    assign w_rm = r_ir[20:16];

    assign w_k_imm12 = {{(K_W-12){1'b0}}, r_ir[21:10]};
    assign w_k_imm9  = {{(K_W-9){r_ir[20]}}, r_ir[20:12]};
    assign w_k_imm19 = {{(K_W-19){r_ir[23]}}, r_ir[23:5]};
    assign w_k_imm26 = {{(K_W-26){r_ir[25]}}, r_ir[25:0]};

    assign w_cb_take = (w_op == OPC_CBNZ) ? ~cif.PRESTAT[FLAG_Z] : cif.PRESTAT[FLAG_Z];

    always_comb begin
        w_alu_fs       = FS_ADD;
        w_alu_sub      = 1'b0;
        w_alu_imm      = 1'b0;
        w_alu_setflags = 1'b0;
        case (w_op)
            OPC_ADDS: w_alu_setflags = 1'b1;
            OPC_SUB:  begin w_alu_fs = FS_SUB; w_alu_sub = 1'b1; end
            OPC_SUBS: begin w_alu_fs = FS_SUB; w_alu_sub = 1'b1; w_alu_setflags = 1'b1; end
            OPC_AND:  w_alu_fs = FS_AND;
            OPC_ORR:  w_alu_fs = FS_ORR;
            OPC_ADDI: w_alu_imm = 1'b1;
            OPC_SUBI: begin w_alu_fs = FS_SUB; w_alu_sub = 1'b1; w_alu_imm = 1'b1; end
            OPC_ANDI: begin w_alu_fs = FS_AND; w_alu_imm = 1'b1; end
            OPC_ORRI: begin w_alu_fs = FS_ORR; w_alu_imm = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        case (w_op)
            OPC_LDUR:           w_exec_next = ST_MEM;
            OPC_CBZ, OPC_CBNZ:  w_exec_next = ST_BRCHK;
            OPC_INVALID:        w_exec_next = ST_HALT;
            default:            w_exec_next = ST_FETCH;
        endcase
    end

    // Reset wins in every state, so an LDUR cut short never reaches WB.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= cif.inst;
                    r_state <= ST_EXEC;
                end
                ST_EXEC:  r_state <= w_exec_next;
                ST_MEM:   r_state <= ST_WB;
                ST_WB:    r_state <= ST_FETCH;
                ST_BRCHK: r_state <= ST_FETCH;
                ST_HALT:  r_state <= ST_HALT;
                default:  r_state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        cif.SA          = '0;
        cif.SB          = '0;
        cif.DA          = '0;
        cif.WR          = 1'b0;
        cif.FS          = '0;
        cif.C0          = 1'b0;
        cif.K           = '0;
        cif.M           = 1'b0;
        cif.EN_ALU      = 1'b0;
        cif.EN_B        = 1'b0;
        cif.EN_PC       = 1'b0;
        cif.EN_ADDR_ALU = 1'b0;
        cif.EN_ADDR_PC  = 1'b0;
        cif.PC_SEL      = 1'b0;
        cif.PS          = PS_HOLD;
        cif.RCS         = 1'b0;
        cif.RWE         = 1'b0;
        cif.ROE         = 1'b0;
        cif.SFL         = 1'b0;
        cif.halted      = 1'b0;

        case (r_state)
            ST_EXEC: begin
                case (w_op)
                    OPC_ADD, OPC_ADDS, OPC_SUB, OPC_SUBS, OPC_AND, OPC_ORR,
                    OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORRI: begin
                        cif.SA     = w_rn;
                        cif.SB     = w_rm;
                        cif.DA     = w_rd;
                        cif.WR     = 1'b1;
                        cif.EN_ALU = 1'b1;
                        cif.FS     = w_alu_fs;
                        cif.C0     = w_alu_sub;
                        cif.M      = w_alu_imm;
                        cif.K      = w_alu_imm ? w_k_imm12 : '0;
                        cif.SFL    = w_alu_setflags;
                        cif.PS     = PS_INC;
                    end
                    OPC_STUR, OPC_LDUR: begin
                        cif.SA          = w_rn;
                        cif.M           = 1'b1;
                        cif.K           = w_k_imm9;
                        cif.FS          = FS_ADD;
                        cif.EN_ADDR_ALU = 1'b1;
                        cif.RCS         = 1'b1;
                        if (w_op == OPC_STUR) begin
                            cif.SB   = w_rd;
                            cif.EN_B = 1'b1;
                            cif.RWE  = 1'b1;
                            cif.PS   = PS_INC;
                        end
                    end
                    OPC_B: begin
                        cif.PC_SEL = 1'b1;
                        cif.K      = w_k_imm26;
                        cif.PS     = PS_OFFSET;
                    end
                    // Pass Rt through the ALU unchanged so Z reflects Rt == 0.
                    OPC_CBZ, OPC_CBNZ: begin
                        cif.SA  = w_rd;
                        cif.M   = 1'b1;
                        cif.FS  = FS_ADD;
                        cif.SFL = 1'b1;
                    end
                    OPC_BCOND: begin
                        if (w_bcond_take) begin
                            cif.PC_SEL = 1'b1;
                            cif.K      = w_k_imm19;
                            cif.PS     = PS_OFFSET;
                        end else begin
                            cif.PS = PS_INC;
                        end
                    end
                    default: ;
                endcase
            end
            ST_MEM, ST_WB: begin
                cif.SA          = w_rn;
                cif.M           = 1'b1;
                cif.K           = w_k_imm9;
                cif.FS          = FS_ADD;
                cif.EN_ADDR_ALU = 1'b1;
                cif.RCS         = 1'b1;
                cif.ROE         = 1'b1;
                if (r_state == ST_WB) begin
                    cif.WR = 1'b1;
                    cif.DA = w_rd;
                    cif.PS = PS_INC;
                end
            end
            ST_BRCHK: begin
                if (w_cb_take) begin
                    cif.PC_SEL = 1'b1;
                    cif.K      = w_k_imm19;
                    cif.PS     = PS_OFFSET;
                end else begin
                    cif.PS = PS_INC;
                end
            end
            ST_HALT:  cif.halted = 1'b1;
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_legv8_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_legv8_control_unit
// Brief    : Directed-vector bench for the LEGv8 control unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_legv8_control_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    legv8_ctrl_if #(.K_W(64), .REG_SEL_W(5)) cif ();

    legv8_control_unit #(.K_W(64), .REG_SEL_W(5)) u_dut (
        .CLK (clk),
        .RST (rst),
        .cif (cif)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [35:0] w_ctrl;
    assign w_ctrl = {cif.SA, cif.SB, cif.DA, cif.WR, cif.FS, cif.C0, cif.M,
                     cif.EN_ALU, cif.EN_B, cif.EN_PC, cif.EN_ADDR_ALU, cif.EN_ADDR_PC,
                     cif.PC_SEL, cif.PS, cif.RCS, cif.RWE, cif.ROE, cif.SFL, cif.halted};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        cif.inst    = 32'h0;
        cif.PRESTAT = 4'h0;
        step();
        step();
        rst = 1'b0;
        check("rst_ctrl", w_ctrl, 0);
        check("rst_k", cif.K, 0);

        // ADD X1,X2,X3
        cif.inst = 32'h8B030041;
        step();
        check("add_sa", cif.SA, 2);
        check("add_sb", cif.SB, 3);
        check("add_da", cif.DA, 1);
        check("add_wr", cif.WR, 1);
        check("add_en_alu", cif.EN_ALU, 1);
        check("add_m", cif.M, 0);
        check("add_ps", cif.PS, 2'b01);
        check("add_fs", cif.FS, 5'b01000);
        check("add_c0_sfl", {cif.C0, cif.SFL}, 0);
        step();
        check("add_fetch", w_ctrl, 0);

        // SUBS X4,X5,X6
        cif.inst = 32'hEB0600A4;
        step();
        check("subs_fs", cif.FS, 5'b01001);
        check("subs_c0", cif.C0, 1);
        check("subs_sfl", cif.SFL, 1);
        check("subs_regs", {cif.SA, cif.SB, cif.DA}, {5'd5, 5'd6, 5'd4});
        step();

        // ADDI X1,X2,#4095 : imm12 zero-extended
        cif.inst = 32'h913FFC41;
        step();
        check("addi_k", cif.K, 64'h0000_0000_0000_0FFF);
        check("addi_m", cif.M, 1);
        check("addi_sfl", cif.SFL, 0);
        step();

        // STUR X3,[X1,#16]
        cif.inst = 32'hF8010023;
        step();
        check("stur_strobes", {cif.RCS, cif.RWE, cif.EN_B, cif.EN_ADDR_ALU, cif.ROE}, 5'b11110);
        check("stur_sb", cif.SB, 3);
        check("stur_sa", cif.SA, 1);
        check("stur_k", cif.K, 16);
        check("stur_ps_wr", {cif.PS, cif.WR}, 3'b010);
        step();
        check("stur_fetch", w_ctrl, 0);

        // LDUR X7,[X2,#-8]
        cif.inst = 32'hF85F8047;
        step();
        check("ldur_exec_k", cif.K, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_exec_strb", {cif.RCS, cif.RWE, cif.EN_B, cif.EN_ADDR_ALU, cif.WR}, 5'b10010);
        check("ldur_exec_ps", cif.PS, 2'b00);
        step();
        check("ldur_mem_strb", {cif.RCS, cif.ROE, cif.WR, cif.PS}, 5'b11000);
        check("ldur_mem_k", cif.K, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        check("ldur_wb_wr", {cif.WR, cif.DA}, {1'b1, 5'd7});
        check("ldur_wb_strb", {cif.RCS, cif.ROE, cif.PS}, 4'b1101);
        step();
        check("ldur_fetch", w_ctrl, 0);

        // LDUR again, reset in MEM
        step();
        step();
        check("ldur2_mem", {cif.ROE, cif.WR}, 2'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ldur2_rst_fetch", w_ctrl, 0);
        cif.inst = 32'h8B030041;
        step();
        check("ldur2_after_rst", {cif.DA, cif.WR, cif.SA}, {5'd1, 1'b1, 5'd2});
        step();

        // CBZ X9,+5, taken
        cif.inst = 32'hB40000A9;
        step();
        check("cbz_exec", {cif.SA, cif.M, cif.SFL, cif.PS, cif.WR}, {5'd9, 1'b1, 1'b1, 2'b00, 1'b0});
        check("cbz_exec_k", cif.K, 0);
        cif.PRESTAT = 4'b0001;
        step();
        check("cbz_taken_ps", cif.PS, 2'b11);
        check("cbz_taken_k", cif.K, 5);
        check("cbz_taken_pcsel", cif.PC_SEL, 1);
        step();
        check("cbz_fetch", w_ctrl, 0);

        // CBZ not taken
        cif.PRESTAT = 4'b0000;
        step();
        step();
        check("cbz_nt", {cif.PS, cif.PC_SEL}, 3'b010);
        step();

        // CBNZ X9,+5 with Z=0 : taken
        cif.inst = 32'hB50000A9;
        step();
        step();
        check("cbnz_taken_ps", cif.PS, 2'b11);
        step();

        // B -1
        cif.inst = 32'h17FFFFFF;
        step();
        check("b_neg", {cif.PS, cif.PC_SEL}, 3'b111);
        check("b_neg_k", cif.K, 64'hFFFF_FFFF_FFFF_FFFF);
        step();

        // B.NE +2 with Z=0
        cif.inst    = 32'h54000041;
        cif.PRESTAT = 4'b0000;
        step();
`ifdef CU_BCOND_EN
        check("bne_taken_ps", cif.PS, 2'b11);
        check("bne_taken_k", cif.K, 2);
        check("bne_sfl", cif.SFL, 0);
        step();
        check("bne_fetch", w_ctrl, 0);
        cif.PRESTAT = 4'b0001;
        step();
        check("bne_nt", {cif.PS, cif.PC_SEL}, 3'b010);
        step();
`else
        check("bcond_off_exec", w_ctrl, 0);
        step();
        check("bcond_off_halt", cif.halted, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif

        // Unrecognised opcode
        cif.inst = 32'h0;
        step();
        check("inv_exec", w_ctrl, 0);
        step();
        check("halt_ctrl", w_ctrl, 36'h1);
        step();
        step();
        step();
        check("halt_hold", cif.halted, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("halt_rst", cif.halted, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
